hazard_unit: RTL and testbench

Stall/flush controller in the ID stage, complementing the forwarding unit in EX. The forwarding unit resolves hazards by bypassing results. This block covers the cases bypassing cannot fix:
- load-use dependencies;
- reads of HI/LO, or a new multiply/divide, while the multi-cycle mul/div unit is still busy;
- wrong-path instructions behind a branch taken in EX.

It drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush. It also keeps a free-running stall-cycle performance counter.

---
 rtl/hazard_unit.sv | 122 ++++++++++++
 tb/tb_hazard_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit
//   ID-stage stall/flush controller. Covers the hazards the EX forwarding unit
//   cannot bypass: load-use dependencies, HI/LO reads or new mul/div issue
//   while the multi-cycle mul/div unit is busy, and wrong-path instructions
//   behind a branch resolved taken in EX. Also counts stall cycles.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   rsIFID, rtIFID    source register fields of the instruction in ID
//   UseRsIFID/UseRtIFID  ID instruction actually reads rs / rt
//   HiLoUseIFID       ID instruction is MFHI/MFLO
//   MulDivIFID        ID instruction is MULT/DIV
//   rtIDEX            destination of the load in EX
//   MemReadIDEX       EX instruction is a load
//   MulDivStartIDEX   mul/div issuing from EX this cycle
//   BranchTakenIDEX   branch/jump in EX resolved taken
//   PCWrite, IFIDWrite   front-end write enables (0 = hold)
//   IDEXBubble        ID/EX loads all-zero control
//   IFIDFlush         IF/ID loads a NOP
//   MulDivBusy        mul/div unit busy (registered state)
//   MulDivState       busy-counter FSM state (IDLE/BUSY), for observation
//   StallCount        free-running count of stall cycles, wraps
module hazard_unit #(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsIFID,
  input  logic [4:0]       rtIFID,
  input  logic             UseRsIFID,
  input  logic             UseRtIFID,
  input  logic             HiLoUseIFID,
  input  logic             MulDivIFID,
  input  logic [4:0]       rtIDEX,
  input  logic             MemReadIDEX,
  input  logic             MulDivStartIDEX,
  input  logic             BranchTakenIDEX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             MulDivBusy,
  output logic [1:0]       MulDivState,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1
  } mdState_t;

  localparam logic [3:0] LATENCY = 4'(MULDIV_LATENCY);

  logic [3:0] busyCnt;
  logic [3:0] busyCntNext;
  mdState_t   state;
  logic       loadUse;
  logic       mdHazard;
  logic       stall;

  // The state is fully encoded by the counter: nonzero means the unit is busy.
  assign state       = (busyCnt != 4'd0) ? BUSY : IDLE;
  assign MulDivState = state;
  assign MulDivBusy  = (state == BUSY);

  // Busy counter: a new issue reloads (priority over decrement). A branch
  // flush does not touch it, since the issued mul/div is older than the branch.
  always_comb begin
    busyCntNext = busyCnt;
    if (MulDivStartIDEX) begin
      busyCntNext = LATENCY;
    end else if (state == BUSY) begin
      busyCntNext = busyCnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busyCnt <= 4'd0;
    end else begin
      busyCnt <= busyCntNext;
    end
  end

  // Hazard detection. Register 0 never carries a dependency.
  // The MulDivStartIDEX term catches the issue cycle, before busyCnt loads.
  always_comb begin
    loadUse  = MemReadIDEX && (rtIDEX != 5'd0) &&
               ((UseRsIFID && (rtIDEX == rsIFID)) ||
                (UseRtIFID && (rtIDEX == rtIFID)));
    mdHazard = (HiLoUseIFID || MulDivIFID) && (MulDivBusy || MulDivStartIDEX);
    stall    = (loadUse || mdHazard) && !BranchTakenIDEX;
  end

  // Control outputs. A taken branch wins: the ID instruction is on the wrong
  // path, so its stall is cancelled and the redirect proceeds.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    if (BranchTakenIDEX) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (stall) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end
  end

  // One increment per stalled cycle regardless of how many hazards coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (stall) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rsIFID;
  logic [4:0] rtIFID;
  logic       UseRsIFID;
  logic       UseRtIFID;
  logic       HiLoUseIFID;
  logic       MulDivIFID;
  logic [4:0] rtIDEX;
  logic       MemReadIDEX;
  logic       MulDivStartIDEX;
  logic       BranchTakenIDEX;

  logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MulDivBusy;
  logic [1:0]  MulDivState;
  logic [31:0] StallCount;

  logic        PCWriteW, IFIDWriteW, IDEXBubbleW, IFIDFlushW, MulDivBusyW;
  logic [1:0]  MulDivStateW;
  logic [3:0]  StallCountW;

  int checks;
  int fails;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_unit #(.MULDIV_LATENCY(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rsIFID(rsIFID), .rtIFID(rtIFID),
    .UseRsIFID(UseRsIFID), .UseRtIFID(UseRtIFID),
    .HiLoUseIFID(HiLoUseIFID), .MulDivIFID(MulDivIFID),
    .rtIDEX(rtIDEX), .MemReadIDEX(MemReadIDEX),
    .MulDivStartIDEX(MulDivStartIDEX), .BranchTakenIDEX(BranchTakenIDEX),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
    .IFIDFlush(IFIDFlush), .MulDivBusy(MulDivBusy),
    .MulDivState(MulDivState), .StallCount(StallCount)
  );

  // narrow-counter instance for the wrap test
  hazard_unit #(.MULDIV_LATENCY(4), .CNT_W(4)) dutW (
    .clk(clk), .rst(rst),
    .rsIFID(rsIFID), .rtIFID(rtIFID),
    .UseRsIFID(UseRsIFID), .UseRtIFID(UseRtIFID),
    .HiLoUseIFID(HiLoUseIFID), .MulDivIFID(MulDivIFID),
    .rtIDEX(rtIDEX), .MemReadIDEX(MemReadIDEX),
    .MulDivStartIDEX(MulDivStartIDEX), .BranchTakenIDEX(BranchTakenIDEX),
    .PCWrite(PCWriteW), .IFIDWrite(IFIDWriteW), .IDEXBubble(IDEXBubbleW),
    .IFIDFlush(IFIDFlushW), .MulDivBusy(MulDivBusyW),
    .MulDivState(MulDivStateW), .StallCount(StallCountW)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsIFID = 5'd0; rtIFID = 5'd0; UseRsIFID = 1'b0; UseRtIFID = 1'b0;
    HiLoUseIFID = 1'b0; MulDivIFID = 1'b0; rtIDEX = 5'd0; MemReadIDEX = 1'b0;
    MulDivStartIDEX = 1'b0; BranchTakenIDEX = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    MulDivStartIDEX = 1'b1;
    step();
    rst = 1'b0;
    MulDivStartIDEX = 1'b0;
    #1;
    checks++; if (MulDivBusy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", MulDivBusy); end
    checks++; if (StallCount !== 32'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", StallCount); end
    checks++; if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush} !== 4'b1100) begin
      fails++; $display("FAIL reset_ctrl: got %b want 1100", {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}); end
  endtask

  task automatic test_load_use();
    do_reset();
    MemReadIDEX = 1'b1; rtIDEX = 5'd5; rsIFID = 5'd5; UseRsIFID = 1'b1;
    #1;
    checks++; if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush} !== 4'b0010) begin
      fails++; $display("FAIL loaduse_stall: got %b want 0010", {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}); end
    step();
    // load moved to MEM; ID/EX now holds the bubble
    MemReadIDEX = 1'b0; rtIDEX = 5'd0;
    #1;
    checks++; if ({PCWrite, IFIDWrite, IDEXBubble} !== 3'b110) begin
      fails++; $display("FAIL loaduse_release: got %b want 110", {PCWrite, IFIDWrite, IDEXBubble}); end
    checks++; if (StallCount !== 32'd1) begin fails++; $display("FAIL loaduse_count: got %0d want 1", StallCount); end
    // register 0 never hazards
    MemReadIDEX = 1'b1; rtIDEX = 5'd0; rsIFID = 5'd0; UseRsIFID = 1'b1;
    #1;
    checks++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL loaduse_r0: PCWrite got %b want 1", PCWrite); end
    // match but rs not read
    rtIDEX = 5'd5; rsIFID = 5'd5; UseRsIFID = 1'b0;
    #1;
    checks++; if (IDEXBubble !== 1'b0) begin fails++; $display("FAIL loaduse_noread: IDEXBubble got %b want 0", IDEXBubble); end
    // rt-side match
    rtIFID = 5'd5; UseRtIFID = 1'b1;
    #1;
    checks++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL loaduse_rt: PCWrite got %b want 0", PCWrite); end
    // rt read but different register
    rtIFID = 5'd6;
    #1;
    checks++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL loaduse_rtdiff: PCWrite got %b want 1", PCWrite); end
    step();
    checks++; if (StallCount !== 32'd1) begin fails++; $display("FAIL loaduse_nocount: got %0d want 1", StallCount); end
    clear_inputs();
  endtask

  task automatic test_muldiv();
    logic expStall;
    logic expBusy;
    do_reset();
    MulDivStartIDEX = 1'b1;
    HiLoUseIFID = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      #1;
      expStall = (c <= 4);
      expBusy  = (c >= 1) && (c <= 4);
      checks++; if (PCWrite !== !expStall) begin
        fails++; $display("FAIL muldiv_stall c%0d: PCWrite got %b want %b", c, PCWrite, !expStall); end
      checks++; if (MulDivBusy !== expBusy) begin
        fails++; $display("FAIL muldiv_busy c%0d: got %b want %b", c, MulDivBusy, expBusy); end
      step();
      MulDivStartIDEX = 1'b0;
    end
    checks++; if (StallCount !== 32'd5) begin fails++; $display("FAIL muldiv_count: got %0d want 5", StallCount); end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    MulDivStartIDEX = 1'b1; MulDivIFID = 1'b1;
    MemReadIDEX = 1'b1; rtIDEX = 5'd9; rsIFID = 5'd9; UseRsIFID = 1'b1;
    step();
    clear_inputs();
    #1;
    checks++; if (StallCount !== 32'd1) begin fails++; $display("FAIL simul_count: got %0d want 1", StallCount); end
    do_reset();
  endtask

  task automatic test_branch_over_stall();
    do_reset();
    MulDivStartIDEX = 1'b1;
    step();
    MulDivStartIDEX = 1'b0;
    // busyCnt = 4; MFHI and load-use in ID on the wrong path
    HiLoUseIFID = 1'b1;
    MemReadIDEX = 1'b1; rtIDEX = 5'd7; rtIFID = 5'd7; UseRtIFID = 1'b1;
    BranchTakenIDEX = 1'b1;
    #1;
    checks++; if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush} !== 4'b1111) begin
      fails++; $display("FAIL branch_ctrl: got %b want 1111", {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}); end
    step();
    checks++; if (StallCount !== 32'd0) begin fails++; $display("FAIL branch_count: got %0d want 0", StallCount); end
    checks++; if (MulDivBusy !== 1'b1) begin fails++; $display("FAIL branch_busy: got %b want 1", MulDivBusy); end
    // busyCnt = 3 now; MFHI waits
    BranchTakenIDEX = 1'b0;
    MemReadIDEX = 1'b0; UseRtIFID = 1'b0;
    #1;
    checks++; if ({PCWrite, IDEXBubble, IFIDFlush} !== 3'b010) begin
      fails++; $display("FAIL midbusy_stall: got %b want 010", {PCWrite, IDEXBubble, IFIDFlush}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (MulDivBusy !== 1'b0) begin fails++; $display("FAIL midbusy_reset: busy got %b want 0", MulDivBusy); end
    checks++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL midbusy_release: PCWrite got %b want 1", PCWrite); end
    checks++; if (StallCount !== 32'd0) begin fails++; $display("FAIL midbusy_count: got %0d want 0", StallCount); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    MulDivStartIDEX = 1'b1;
    step();
    // busyCnt = 4; a reload while busy restarts the full latency
    step();
    MulDivStartIDEX = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (MulDivBusy !== (c < 4)) begin
        fails++; $display("FAIL b2b_busy c%0d: got %b want %b", c, MulDivBusy, (c < 4)); end
      step();
    end
    checks++; if (StallCount !== 32'd0) begin fails++; $display("FAIL b2b_count: got %0d want 0", StallCount); end
  endtask

  task automatic test_wrap();
    do_reset();
    MemReadIDEX = 1'b1; rtIDEX = 5'd3; rsIFID = 5'd3; UseRsIFID = 1'b1;
    for (int c = 0; c < 17; c++) step();
    clear_inputs();
    #1;
    checks++; if (StallCountW !== 4'd1) begin fails++; $display("FAIL wrap_narrow: got %0d want 1", StallCountW); end
    checks++; if (StallCount !== 32'd17) begin fails++; $display("FAIL wrap_wide: got %0d want 17", StallCount); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    clear_inputs();
    step();
    test_reset();
    test_load_use();
    test_muldiv();
    test_simultaneous();
    test_branch_over_stall();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
